// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state codes, opcode constants and select encodings for ctrl_multicycle
package ctrl_pkg;

    localparam logic [4:0] S_RESET_SP = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_MEM_WAIT = 5'd2;
    localparam logic [4:0] S_IR_LOAD  = 5'd3;
    localparam logic [4:0] S_DECODE   = 5'd4;
    localparam logic [4:0] S_EXEC_R   = 5'd5;
    localparam logic [4:0] S_WB_R     = 5'd6;
    localparam logic [4:0] S_EXEC_I   = 5'd7;
    localparam logic [4:0] S_WB_I     = 5'd8;
    localparam logic [4:0] S_ADDR     = 5'd9;
    localparam logic [4:0] S_LW_RD    = 5'd10;
    localparam logic [4:0] S_LW_WB    = 5'd11;
    localparam logic [4:0] S_SW       = 5'd12;
    localparam logic [4:0] S_BEQ      = 5'd13;
    localparam logic [4:0] S_JUMP     = 5'd14;
    localparam logic [4:0] S_JAL      = 5'd15;
    localparam logic [4:0] S_JR       = 5'd16;
    localparam logic [4:0] S_ILLEGAL  = 5'd17;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] REGDST_RT    = 3'd0;
    localparam logic [2:0] REGDST_RD    = 3'd1;
    localparam logic [2:0] REGDST_DATA2 = 3'd2;
    localparam logic [2:0] REGDST_SP    = 3'd3;
    localparam logic [2:0] REGDST_RA    = 3'd4;

    localparam logic [2:0] WDSEL_ALUOUT = 3'd0;
    localparam logic [2:0] WDSEL_MDR    = 3'd1;
    localparam logic [2:0] WDSEL_PC     = 3'd2;
    localparam logic [2:0] WDSEL_SPINIT = 3'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_FUNCT = 3'd2;
    localparam logic [2:0] ALUOP_AND   = 3'd3;
    localparam logic [2:0] ALUOP_OR    = 3'd4;

    localparam logic [31:0] SP_INIT = 32'd227;

    function automatic logic [4:0] dispatch(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI:  return S_EXEC_I;
            OP_LW,
            OP_SW:    return S_ADDR;
            OP_BEQ:   return S_BEQ;
            OP_J:     return S_JUMP;
            OP_JAL:   return S_JAL;
            default:  return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - memory latency counter: start loads 1, done on the last wait cycle
module mem_wait_cnt #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

    logic [2:0] cnt;

    // cnt==0 means idle; a wait occupies MEM_LAT-1 cycles counting 1..LAST
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (start) begin
            cnt <= 3'd1;
        end else if (cnt != 3'd0) begin
            cnt <= (cnt == LAST) ? 3'd0 : cnt + 3'd1;
        end
    end

    assign done = (cnt != 3'd0) && (cnt == LAST);

endmodule

// File: rtl/ctrl_multicycle.sv
// rtl/ctrl_multicycle.sv - Moore control FSM for the multicycle datapath; OPCODE_EXC_EN enables illegal-opcode trap
module ctrl_multicycle
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
`ifdef OPCODE_EXC_EN
    ,
    parameter logic [31:0] EXC_VEC = 32'h000000FF
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_wr_cond,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic [2:0] reg_dst_sel,
    output logic [2:0] wd_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       epc_write,
    output logic [4:0] state_o
);

    localparam bit HAS_WAIT = (MEM_LAT > 1);

    logic [4:0] state, next_state;
    logic       ret_lw;
    logic       wait_start, wait_done;

    // the branch decision is taken in the datapath via pc_wr_cond
    logic unused_zero;
    assign unused_zero = zero;

    assign wait_start = HAS_WAIT && ((state == S_FETCH) || (state == S_LW_RD));
    assign state_o    = state;

    mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .start (wait_start),
        .done  (wait_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_RESET_SP;
            ret_lw <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_LW_RD)
                ret_lw <= 1'b1;
            else if (state == S_FETCH)
                ret_lw <= 1'b0;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = HAS_WAIT ? S_MEM_WAIT : S_IR_LOAD;
            S_MEM_WAIT: next_state = !wait_done ? S_MEM_WAIT : (ret_lw ? S_LW_WB : S_IR_LOAD);
            S_IR_LOAD:  next_state = S_DECODE;
            S_DECODE:   next_state = dispatch(opcode, funct);
            S_EXEC_R:   next_state = S_WB_R;
            S_EXEC_I:   next_state = S_WB_I;
            S_ADDR:     next_state = (opcode == OP_LW) ? S_LW_RD : S_SW;
            S_LW_RD:    next_state = HAS_WAIT ? S_MEM_WAIT : S_LW_WB;
            default:    next_state = S_FETCH;
        endcase
    end

    // outputs decode from state only, forced quiet while reset is held
    always_comb begin
        pc_write    = 1'b0;
        pc_wr_cond  = 1'b0;
        pc_src      = PCSRC_ALU;
        iord        = 1'b0;
        mem_wr      = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst_sel = REGDST_RT;
        wd_sel      = WDSEL_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_op      = ALUOP_ADD;
        epc_write   = 1'b0;
        if (!reset) begin
            case (state)
                S_RESET_SP: begin
                    reg_write = 1'b1; reg_dst_sel = REGDST_SP; wd_sel = WDSEL_SPINIT;
                end
                S_FETCH: begin
                    alu_src_b = SRCB_FOUR; pc_write = 1'b1;
                end
                S_IR_LOAD: ir_write = 1'b1;
                S_DECODE:  alu_src_b = SRCB_IMMSH;
                S_EXEC_R: begin
                    alu_src_a = 1'b1; alu_op = ALUOP_FUNCT;
                end
                S_WB_R: begin
                    reg_write = 1'b1; reg_dst_sel = REGDST_RD;
                end
                S_EXEC_I, S_ADDR: begin
                    alu_src_a = 1'b1; alu_src_b = SRCB_IMM;
                end
                S_WB_I:  reg_write = 1'b1;
                S_LW_RD: iord = 1'b1;
                S_LW_WB: begin
                    reg_write = 1'b1; wd_sel = WDSEL_MDR;
                end
                S_SW: begin
                    iord = 1'b1; mem_wr = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1; alu_op = ALUOP_SUB; pc_wr_cond = 1'b1; pc_src = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write = 1'b1; pc_src = PCSRC_JUMP;
                end
                S_JAL: begin
                    reg_write = 1'b1; reg_dst_sel = REGDST_RA; wd_sel = WDSEL_PC;
                    pc_write = 1'b1; pc_src = PCSRC_JUMP;
                end
                S_JR: begin
                    pc_write = 1'b1; pc_src = PCSRC_REG;
                end
`ifdef OPCODE_EXC_EN
                S_ILLEGAL: begin
                    epc_write = 1'b1; alu_src_b = SRCB_FOUR; alu_op = ALUOP_SUB;
                    pc_write = 1'b1; pc_src = PCSRC_REG;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_multicycle.sv
// tb/tb_ctrl_multicycle.sv - table-driven scoreboard bench for ctrl_multicycle
module tb_ctrl_multicycle;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pc_write, pc_wr_cond, iord, mem_wr, ir_write, reg_write, alu_src_a, epc_write;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] reg_dst_sel, wd_sel, alu_op;
    logic [4:0] state_o;

    ctrl_multicycle #(.MEM_LAT(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_wr_cond(pc_wr_cond), .pc_src(pc_src), .iord(iord),
        .mem_wr(mem_wr), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst_sel(reg_dst_sel), .wd_sel(wd_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .epc_write(epc_write), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  st;
        logic [20:0] outs;
        string       tag;
    } entry_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         n;
        logic [4:0] tail [4];
    } vec_t;

    entry_t q[$];
    vec_t   vecs[10];
    int     n_cmp = 0;
    int     n_err = 0;

    function automatic logic [20:0] mk(input logic pcw, input logic pcc, input logic [1:0] pcs,
                                       input logic io, input logic mw, input logic irw,
                                       input logic rw, input logic [2:0] dst, input logic [2:0] wd,
                                       input logic a, input logic [1:0] b, input logic [2:0] op,
                                       input logic epc);
        return {pcw, pcc, pcs, io, mw, irw, rw, dst, wd, a, b, op, epc};
    endfunction

    // expected outputs of each state, written from the state descriptions
    function automatic logic [20:0] exp_out(input logic [4:0] s);
        case (s)
            S_RESET_SP: return mk(0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0);
            S_FETCH:    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            S_IR_LOAD:  return mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            S_DECODE:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
            S_EXEC_R:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
            S_WB_R:     return mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
            S_EXEC_I:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
            S_WB_I:     return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            S_ADDR:     return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
            S_LW_RD:    return mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            S_LW_WB:    return mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
            S_SW:       return mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            S_BEQ:      return mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            S_JUMP:     return mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            S_JAL:      return mk(1, 0, 2, 0, 0, 0, 1, 4, 2, 0, 0, 0, 0);
            S_JR:       return mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef OPCODE_EXC_EN
            S_ILLEGAL:  return mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
`endif
            default:    return 21'd0;
        endcase
    endfunction

    function automatic logic [20:0] actual_outs();
        return {pc_write, pc_wr_cond, pc_src, iord, mem_wr, ir_write, reg_write,
                reg_dst_sel, wd_sel, alu_src_a, alu_src_b, alu_op, epc_write};
    endfunction

    task automatic check(input string tag, input logic [4:0] est, input logic [20:0] eouts);
        logic [20:0] a;
        a = actual_outs();
        n_cmp++;
        if (state_o !== est || a !== eouts) begin
            n_err++;
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     tag, state_o, a, est, eouts);
        end
    endtask

    task automatic push(input logic [4:0] s, input string tag);
        entry_t e;
        e.st = s; e.outs = exp_out(s); e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_instr(input int i);
        string t;
        t = $sformatf("vec%0d", i);
        push(S_FETCH, {t, "_fetch"});
        push(S_MEM_WAIT, {t, "_wait"});
        push(S_IR_LOAD, {t, "_irload"});
        push(S_DECODE, {t, "_decode"});
        for (int k = 0; k < vecs[i].n; k++)
            push(vecs[i].tail[k], $sformatf("%s_tail%0d", t, k));
    endtask

    // compare one entry per cycle; leaves time at the next cycle's sample point
    task automatic drain();
        entry_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, e.st, e.outs);
            @(negedge clk); #1;
        end
    endtask

    task automatic set_vec(input int i, input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int n, input logic [4:0] t0, input logic [4:0] t1,
                           input logic [4:0] t2, input logic [4:0] t3);
        vecs[i].op = op; vecs[i].fn = fn; vecs[i].z = z; vecs[i].n = n;
        vecs[i].tail[0] = t0; vecs[i].tail[1] = t1; vecs[i].tail[2] = t2; vecs[i].tail[3] = t3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        set_vec(0, 6'h00, 6'h20, 1'b0, 2, S_EXEC_R, S_WB_R, 5'd0, 5'd0);
        set_vec(1, 6'h03, 6'h00, 1'b0, 1, S_JAL, 5'd0, 5'd0, 5'd0);
        set_vec(2, 6'h04, 6'h00, 1'b0, 1, S_BEQ, 5'd0, 5'd0, 5'd0);
        set_vec(3, 6'h04, 6'h00, 1'b1, 1, S_BEQ, 5'd0, 5'd0, 5'd0);
        set_vec(4, 6'h3F, 6'h00, 1'b0, 1, S_ILLEGAL, 5'd0, 5'd0, 5'd0);
        set_vec(5, 6'h08, 6'h00, 1'b0, 2, S_EXEC_I, S_WB_I, 5'd0, 5'd0);
        set_vec(6, 6'h23, 6'h00, 1'b0, 4, S_ADDR, S_LW_RD, S_MEM_WAIT, S_LW_WB);
        set_vec(7, 6'h2B, 6'h00, 1'b0, 2, S_ADDR, S_SW, 5'd0, 5'd0);
        set_vec(8, 6'h02, 6'h00, 1'b0, 1, S_JUMP, 5'd0, 5'd0, 5'd0);
        set_vec(9, 6'h00, 6'h08, 1'b0, 1, S_JR, 5'd0, 5'd0, 5'd0);

        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_held", 5'd0, 21'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        push(S_RESET_SP, "reset_sp");
        drain();

        for (int i = 0; i < 10; i++) begin
            opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
            push_instr(i);
            drain();
        end

        // reset asserted while a load sits in its memory wait
        opcode = 6'h23; funct = 6'h00; zero = 1'b0;
        push(S_FETCH, "lwrst_fetch");
        push(S_MEM_WAIT, "lwrst_wait0");
        push(S_IR_LOAD, "lwrst_irload");
        push(S_DECODE, "lwrst_decode");
        push(S_ADDR, "lwrst_addr");
        push(S_LW_RD, "lwrst_rd");
        drain();
        check("lwrst_in_wait", S_MEM_WAIT, 21'd0);
        reset = 1'b1;
        #1 check("lwrst_asserted", 5'd0, 21'd0);
        @(posedge clk); #1 check("lwrst_held_edge", 5'd0, 21'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        opcode = 6'h00; funct = 6'h20;
        push(S_RESET_SP, "lwrst_restart_sp");
        push_instr(0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
